// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bus between the timing generator and pixel logic
// Purpose: carries the count enable into the generator and the registered raster
//          timing (syncs, display enable, coordinates, strobes, frame count) out.
// Ports (master = generator side):
//   ena          in  count enable; low freezes the raster
//   hsync/vsync  out sync outputs at their configured active level
//   display_on   out inside the visible area
//   hpos/vpos    out current column / line
//   pix_stb      out one-clk pulse per pixel advance
//   line_start   out one-clk pulse when hpos enters 0
//   frame_start  out one-clk pulse when (hpos, vpos) enters (0, 0)
//   frame_count  out frames started since reset, mod 256
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          ena;
  logic          hsync;
  logic          vsync;
  logic          display_on;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          pix_stb;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_count;

  modport master (
    input  ena,
    output hsync, vsync, display_on, hpos, vpos,
    output pix_stb, line_start, frame_start, frame_count
  );

  modport slave (
    output ena,
    input  hsync, vsync, display_on, hpos, vpos,
    input  pix_stb, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Purpose: divides clk down to the pixel rate and walks (hpos, vpos) over the
//          full raster, producing registered syncs, display enable, strobes
//          and a frame counter.
// Ports:
//   clk    in  pixel-domain clock
//   rst_n  in  asynchronous active-low reset
//   vga    master side of vga_timing_gen_if (ena in, timing outputs out)
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIX_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic          H_ACT_LVL = (H_POL != 0);
  localparam logic          V_ACT_LVL = (V_POL != 0);

  logic [DW-1:0] div_q, div_next;
  logic [HW-1:0] hpos_q, h_next;
  logic [VW-1:0] vpos_q, v_next;
  logic          tick;
  logic          hsync_q, vsync_q, de_q;
  logic          hs_next, vs_next, de_next;
  logic          pix_q, line_q, frame_q;
  logic          line_next, frame_next;
  logic [7:0]    fc_q;

  always_comb begin
    tick     = vga.ena && (div_q == DIV_LAST);
    div_next = div_q;
    h_next   = hpos_q;
    v_next   = vpos_q;
    if (vga.ena) begin
      div_next = tick ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      if (hpos_q == H_LAST) begin
        h_next = '0;
        v_next = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end else begin
        h_next = hpos_q + 1'b1;
      end
    end
    // Decodes look at the position being entered so they line up with hpos/vpos.
    hs_next    = ((int'(h_next) >= HS_START) && (int'(h_next) < HS_END)) ? H_ACT_LVL : ~H_ACT_LVL;
    vs_next    = ((int'(v_next) >= VS_START) && (int'(v_next) < VS_END)) ? V_ACT_LVL : ~V_ACT_LVL;
    de_next    = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
    line_next  = tick && (h_next == '0);
    frame_next = line_next && (v_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      hpos_q  <= H_LAST;
      vpos_q  <= V_LAST;
      hsync_q <= ~H_ACT_LVL;
      vsync_q <= ~V_ACT_LVL;
      de_q    <= 1'b0;
      pix_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      div_q   <= div_next;
      hpos_q  <= h_next;
      vpos_q  <= v_next;
      // Strobes are plain copies of the tick, so they drop to 0 whenever ena is low.
      pix_q   <= tick;
      line_q  <= line_next;
      frame_q <= frame_next;
      // Level outputs only move on a tick, keeping the reset levels until the first pixel.
      if (tick) begin
        hsync_q <= hs_next;
        vsync_q <= vs_next;
        de_q    <= de_next;
      end
      if (frame_next) begin
        fc_q <= fc_q + 8'd1;
      end
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = de_q;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.pix_stb     = pix_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;
  assign vga.frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int H_ACT = 8;
  localparam int H_FP  = 2;
  localparam int H_SY  = 3;
  localparam int H_BP  = 3;
  localparam int V_ACT = 6;
  localparam int V_FP  = 1;
  localparam int V_SY  = 2;
  localparam int V_BP  = 1;
  localparam int HT    = H_ACT + H_FP + H_SY + H_BP;
  localparam int VT    = V_ACT + V_FP + V_SY + V_BP;
  localparam int F     = HT * VT;
  localparam int DIV1  = 1;
  localparam int DIV2  = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference state: enabled clocks since reset and whether the last edge was a tick.
  int e1, e2;
  bit stb1, stb2;

  vga_timing_gen_if #(.HW(4), .VW(4)) b1();
  vga_timing_gen_if #(.HW(4), .VW(4)) b2();

  vga_timing_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .H_POL(0), .V_POL(0), .PIX_DIV(DIV1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .vga(b1)
  );

  vga_timing_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .H_POL(1), .V_POL(1), .PIX_DIV(DIV2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .vga(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs from the raster rules: t ticks since reset puts the beam at
  // linear index (t-1) mod F; frames started is ceil(t/F).
  task automatic check_model(input string n, input int e, input int div, input bit stb,
                             input bit hpol, input bit vpol,
                             input logic [3:0] h_o, input logic [3:0] v_o,
                             input logic hs_o, input logic vs_o, input logic de_o,
                             input logic ps_o, input logic ls_o, input logic fs_o,
                             input logic [7:0] fc_o);
    int t, p, h, v, fc;
    bit hs_a, vs_a, de;
    t    = e / div;
    p    = (t + F - 1) % F;
    h    = p % HT;
    v    = p / HT;
    fc   = ((t + F - 1) / F) % 256;
    hs_a = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY);
    vs_a = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY);
    de   = (h < H_ACT) && (v < V_ACT);
    check({n, ".hpos"},        32'(h_o),  32'(h));
    check({n, ".vpos"},        32'(v_o),  32'(v));
    check({n, ".hsync"},       32'(hs_o), 32'(hs_a ? hpol : !hpol));
    check({n, ".vsync"},       32'(vs_o), 32'(vs_a ? vpol : !vpol));
    check({n, ".display_on"},  32'(de_o), 32'(de));
    check({n, ".pix_stb"},     32'(ps_o), 32'(stb));
    check({n, ".line_start"},  32'(ls_o), 32'(stb && (h == 0)));
    check({n, ".frame_start"}, 32'(fs_o), 32'(stb && (p == 0)));
    check({n, ".frame_count"}, 32'(fc_o), 32'(fc));
  endtask

  task automatic compare_all();
    check_model("d1", e1, DIV1, stb1, 1'b0, 1'b0, b1.hpos, b1.vpos, b1.hsync, b1.vsync,
                b1.display_on, b1.pix_stb, b1.line_start, b1.frame_start, b1.frame_count);
    check_model("d2", e2, DIV2, stb2, 1'b1, 1'b1, b2.hpos, b2.vpos, b2.hsync, b2.vsync,
                b2.display_on, b2.pix_stb, b2.line_start, b2.frame_start, b2.frame_count);
  endtask

  // One clock: advance the reference on the edge, compare on the following negedge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      e1 = 0; stb1 = 1'b0;
      e2 = 0; stb2 = 1'b0;
    end else begin
      if (b1.ena) begin e1++; stb1 = (e1 % DIV1 == 0); end else stb1 = 1'b0;
      if (b2.ena) begin e2++; stb2 = (e2 % DIV2 == 0); end else stb2 = 1'b0;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int t1, p1, n;
    bit found;
    checks = 0;
    errors = 0;
    e1 = 0; e2 = 0; stb1 = 1'b0; stb2 = 1'b0;
    rst_n  = 1'b0;
    b1.ena = 1'b1;
    b2.ena = 1'b1;

    // Reset values with ena high.
    repeat (4) step();
    check("rst_hpos", 32'(b1.hpos), 32'(HT - 1));
    check("rst_vpos", 32'(b1.vpos), 32'(VT - 1));
    check("rst_hsync_lowpol", 32'(b1.hsync), 32'd1);
    check("rst_hsync_highpol", 32'(b2.hsync), 32'd0);

    // Release between edges; the first edge after release is the first tick.
    rst_n = 1'b1;
    step();
    check("first_hpos", 32'(b1.hpos), 32'd0);
    check("first_vpos", 32'(b1.vpos), 32'd0);
    check("first_frame_start", 32'(b1.frame_start), 32'd1);
    check("first_display_on", 32'(b1.display_on), 32'd1);
    check("first_frame_count", 32'(b1.frame_count), 32'd1);
    check("d2_no_tick_yet", 32'(b2.pix_stb), 32'd0);
    step();
    check("second_hpos", 32'(b1.hpos), 32'd1);
    check("second_frame_start", 32'(b1.frame_start), 32'd0);

    // Randomised enables.
    for (int i = 0; i < 3000; i++) begin
      b1.ena = ($urandom_range(0, 4) != 0);
      b2.ena = ($urandom_range(0, 4) != 0);
      step();
    end

    // Mid-line freeze of both generators for 10 clocks, then resume.
    b1.ena = 1'b1; b2.ena = 1'b1;
    repeat (5) step();
    b1.ena = 1'b0; b2.ena = 1'b0;
    repeat (10) step();
    b1.ena = 1'b1; b2.ena = 1'b1;
    repeat (40) step();

    // Run until the 256th frame_start of dut1 and confirm the counter wrapped.
    n = 0;
    while ((e1 / DIV1) != 255 * F + 1 && n < 60000) begin
      step();
      n++;
    end
    check("wrap_reached", 32'((e1 / DIV1) == 255 * F + 1), 32'd1);
    check("wrap_frame_start", 32'(b1.frame_start), 32'd1);
    check("wrap_frame_count", 32'(b1.frame_count), 32'd0);
    repeat (3 * F) step();

    // Mid-frame asynchronous reset at line 4, column 5.
    found = 1'b0;
    for (int i = 0; i < 2 * F && !found; i++) begin
      t1 = e1 / DIV1;
      p1 = (t1 + F - 1) % F;
      if (p1 == 4 * HT + 5) found = 1'b1;
      else step();
    end
    check("midframe_reached", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    e1 = 0; stb1 = 1'b0;
    e2 = 0; stb2 = 1'b0;
    #1;
    check("async_rst_hpos", 32'(b1.hpos), 32'(HT - 1));
    check("async_rst_vpos", 32'(b1.vpos), 32'(VT - 1));
    compare_all();
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * F; i++) begin
      b1.ena = ($urandom_range(0, 3) != 0);
      b2.ena = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
